// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle 8x8 unsigned multiplier (16-bit product) and 8/8 unsigned
// divider (quotient + remainder). It has no arithmetic of its own: every
// add or subtract is done by one shared, external 8-bit adder_subtractor,
// driven through as_a / as_b / as_subtract and read back via as_r / as_carry.
//
// Parameters:
//   ITERATIONS  number of shift/add or shift/subtract steps. Must equal the
//               operand width, so only 8 is supported.
//
// Optional feature (compile-time macro ALU_SEQ_ZERO_SKIP_EN):
//   When defined, a zero multiplicand/dividend, or a zero multiplier, goes
//   straight to DONE with an all-zero result (one-cycle latency, busy never
//   rises). A zero divisor still reports divide-by-zero. When undefined,
//   every multiply and non-zero-divisor divide runs all iterations.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, op         request pulse (op: 0 = multiply, 1 = divide)
//   operand_a/_b      multiplicand/dividend, multiplier/divisor
//   busy, done        iterating flag, one-cycle completion pulse
//   result_lo/_hi     product[7:0]/quotient, product[15:8]/remainder
//   div_by_zero       divide with operand_b == 0, valid with done
//   as_a, as_b,
//   as_subtract       drive to the external adder_subtractor
//   as_r, as_carry    result from the adder_subtractor (carry=1: no borrow)
//   state_dbg         current FSM state (0 IDLE, 1 MUL, 2 DIV, 3 DONE)
//
// Handshake: start is a request pulse and is only accepted when busy is
// low (IDLE or DONE); a start seen while busy is dropped. Each accepted
// request produces exactly one done pulse, after which results and
// div_by_zero stay stable until the next accepted start or reset. A start
// during the done cycle is accepted (back-to-back) and done does not repeat.
// ---------------------------------------------------------------------------
module alu_sequencer #(
  parameter int ITERATIONS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result_lo,
  output logic [7:0] result_hi,
  output logic       div_by_zero,
  output logic [7:0] as_a,
  output logic [7:0] as_b,
  output logic       as_subtract,
  input  logic [7:0] as_r,
  input  logic       as_carry,
  output logic [1:0] state_dbg
);

  localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [7:0]      acc;
  logic [7:0]      mq;
  logic [7:0]      dvsr;
  logic [CW-1:0]   count;

  logic            accept;
  logic            div_zero;
  logic            skip;
  logic            last_step;

  logic [8:0]      mul_sum;
  logic [7:0]      mul_acc;
  logic [7:0]      mul_mq;
  logic [7:0]      div_acc_s;
  logic [7:0]      div_mq_s;
  logic            div_take;
  logic [7:0]      div_acc;
  logic [7:0]      div_mq;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
  assign div_zero  = op && (operand_b == 8'd0);
  assign last_step = (count == CW'(ITERATIONS - 1));

`ifdef ALU_SEQ_ZERO_SKIP_EN
  // Divide-by-zero wins over the zero shortcut.
  assign skip = !div_zero && ((operand_a == 8'd0) || (!op && (operand_b == 8'd0)));
`else
  assign skip = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (div_zero || skip) begin
            state_nxt = S_DONE;
          end else if (op) begin
            state_nxt = S_DIV;
          end else begin
            state_nxt = S_MUL;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        if (last_step) state_nxt = S_DONE;
      end
      S_DIV: begin
        if (last_step) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (status and adder drive)
  // -------------------------------------------------------------------------
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    as_a        = 8'd0;
    as_b        = 8'd0;
    as_subtract = 1'b0;
    state_dbg   = state;
    case (state)
      S_MUL: begin
        busy = 1'b1;
        as_a = acc;
        as_b = dvsr;
      end
      S_DIV: begin
        busy        = 1'b1;
        as_a        = div_acc_s;
        as_b        = dvsr;
        as_subtract = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Step datapath
  // -------------------------------------------------------------------------
  always_comb begin
    // Multiply: conditionally add the multiplicand into the upper half,
    // then shift the 17-bit {carry, acc, mq} right by one. The multiplier
    // bit just consumed falls off the bottom of mq.
    mul_sum = mq[0] ? {as_carry, as_r} : {1'b0, acc};
    mul_acc = mul_sum[8:1];
    mul_mq  = {mul_sum[0], mq[7:1]};

    // Restoring divide: shift {acc, mq} left, trial-subtract the divisor
    // from the upper half. acc[7] shifted out means the partial remainder
    // is >= 256 > divisor, so the subtract always succeeds and its 8-bit
    // result is exact.
    div_acc_s = {acc[6:0], mq[7]};
    div_mq_s  = {mq[6:0], 1'b0};
    div_take  = acc[7] | as_carry;
    div_acc   = div_take ? as_r : div_acc_s;
    div_mq    = {div_mq_s[7:1], div_take};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= 8'd0;
      mq          <= 8'd0;
      dvsr        <= 8'd0;
      count       <= '0;
      result_lo   <= 8'd0;
      result_hi   <= 8'd0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      acc         <= 8'd0;
      mq          <= operand_a;
      dvsr        <= operand_b;
      count       <= '0;
      div_by_zero <= 1'b0;
      if (div_zero) begin
        result_lo   <= 8'hFF;
        result_hi   <= operand_a;
        div_by_zero <= 1'b1;
      end else if (skip) begin
        result_lo <= 8'd0;
        result_hi <= 8'd0;
      end
    end else if (state == S_MUL) begin
      acc   <= mul_acc;
      mq    <= mul_mq;
      count <= count + 1'b1;
      if (last_step) begin
        result_hi <= mul_acc;
        result_lo <= mul_mq;
      end
    end else if (state == S_DIV) begin
      acc   <= div_acc;
      mq    <= div_mq;
      count <= count + 1'b1;
      if (last_step) begin
        result_hi <= div_acc;
        result_lo <= div_mq;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Bench for alu_sequencer. The external adder_subtractor is modelled here as
// plain 9-bit arithmetic. Expected results come from integer *, / and %
// and are queued in exp_q; each scenario task pops and compares inline.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       op;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       busy;
  logic       done;
  logic [7:0] result_lo;
  logic [7:0] result_hi;
  logic       div_by_zero;
  logic [7:0] as_a;
  logic [7:0] as_b;
  logic       as_subtract;
  logic [7:0] as_r;
  logic       as_carry;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // {div_by_zero, result_hi, result_lo}
  logic [16:0] exp_q[$];

  // -------------------------------------------------------------------------
  // Clock / reset block
  // -------------------------------------------------------------------------
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // DUT and adder_subtractor model
  // -------------------------------------------------------------------------
  alu_sequencer #(.ITERATIONS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero),
    .as_a        (as_a),
    .as_b        (as_b),
    .as_subtract (as_subtract),
    .as_r        (as_r),
    .as_carry    (as_carry),
    .state_dbg   (state_dbg)
  );

  logic [8:0] as_sum;
  assign as_sum   = as_subtract ? ({1'b0, as_a} + {1'b0, ~as_b} + 9'd1)
                                : ({1'b0, as_a} + {1'b0, as_b});
  assign as_r     = as_sum[7:0];
  assign as_carry = as_sum[8];

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  function automatic logic [16:0] model_result(input logic o, input logic [7:0] a,
                                               input logic [7:0] b);
    int p;
    if (o && b == 8'd0) return {1'b1, a, 8'hFF};
    if (!o) begin
      p = int'(a) * int'(b);
      return {1'b0, p[15:0]};
    end
    return {1'b0, 8'(int'(a) % int'(b)), 8'(int'(a) / int'(b))};
  endfunction

  function automatic int model_latency(input logic o, input logic [7:0] a,
                                       input logic [7:0] b);
    if (o && b == 8'd0) return 1;
`ifdef ALU_SEQ_ZERO_SKIP_EN
    if (a == 8'd0 || (!o && b == 8'd0)) return 1;
`endif
    return 9;
  endfunction

  // -------------------------------------------------------------------------
  // Driver: called just after a falling edge. Raises start for one cycle and
  // waits (bounded) for done. lat = falling edges from request to done, or -1.
  // -------------------------------------------------------------------------
  task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_n, output logic [16:0] got);
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    lat       = -1;
    busy_n    = 0;
    got       = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        lat = i;
        got = {div_by_zero, result_hi, result_lo};
        break;
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op = 1'b0; operand_a = 8'd0; operand_b = 8'd0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, div_by_zero, result_lo, result_hi, as_a, as_b, as_subtract} !== 28'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {busy, done, div_by_zero, result_lo, result_hi, as_a, as_b, as_subtract});
    end
    total++;
    if (state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multiply();
    int lat, bn;
    logic [16:0] got, exp;
    run_op(1'b0, 8'd13, 8'd11, lat, bn, got);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL mul13x11_latency: got %0d want 9", lat); end
    total++;
    if (bn !== 8) begin bad++; $display("FAIL mul13x11_busy: got %0d want 8", bn); end
    total++;
    if (got !== 17'h0008F) begin bad++; $display("FAIL mul13x11_result: got %h want 0008f", got); end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse: got %b want 0", done); end

    exp_q.push_back(model_result(1'b0, 8'd255, 8'd255));
    run_op(1'b0, 8'd255, 8'd255, lat, bn, got);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp || exp !== 17'h0FE01) begin
      bad++; $display("FAIL mul255x255_result: got %h want 0fe01", got);
    end
    @(negedge clk);
  endtask

  task automatic test_divide();
    int lat, bn;
    logic [16:0] got, exp;
    logic [7:0] da [4] = '{8'd200, 8'd255, 8'd7, 8'd255};
    logic [7:0] db [4] = '{8'd7, 8'd1, 8'd200, 8'd255};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model_result(1'b1, da[i], db[i]));
      run_op(1'b1, da[i], db[i], lat, bn, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL div_%0d_%0d_result: got %h want %h", da[i], db[i], got, exp);
      end
      total++;
      if (lat !== 9) begin
        bad++; $display("FAIL div_%0d_%0d_latency: got %0d want 9", da[i], db[i], lat);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bn;
    logic [16:0] got;
    run_op(1'b1, 8'd42, 8'd0, lat, bn, got);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    total++;
    if (bn !== 0) begin bad++; $display("FAIL dbz_busy: got %0d want 0", bn); end
    total++;
    if (got !== 17'h12AFF) begin bad++; $display("FAIL dbz_result: got %h want 12aff", got); end
    @(negedge clk);
    total++;
    if ({done, state_dbg} !== 3'b000) begin
      bad++; $display("FAIL dbz_back_to_idle: got %b want 000", {done, state_dbg});
    end
    total++;
    if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_hold: got %b want 1", div_by_zero); end
    run_op(1'b0, 8'd2, 8'd3, lat, bn, got);
    total++;
    if (got !== 17'h00006) begin bad++; $display("FAIL dbz_clear: got %h want 00006", got); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic [16:0] got;
    op = 1'b0; operand_a = 8'd3; operand_b = 8'd5; start = 1'b1;
    lat = -1; got = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 3) begin
        op = 1'b0; operand_a = 8'd6; operand_b = 8'd6; start = 1'b1;
      end
      if (done) begin
        lat = i;
        got = {div_by_zero, result_hi, result_lo};
        break;
      end
    end
    total++;
    if (lat !== 9) begin bad++; $display("FAIL busy_ignore_latency: got %0d want 9", lat); end
    total++;
    if (got !== 17'h0000F) begin bad++; $display("FAIL busy_ignore_result: got %h want 0000f", got); end
  endtask

  // Entered in the DONE cycle left by test_busy_ignore.
  task automatic test_back_to_back();
    int lat, bn;
    logic [16:0] got;
    run_op(1'b0, 8'd6, 8'd6, lat, bn, got);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL b2b_latency: got %0d want 9", lat); end
    total++;
    if (got !== 17'h00024) begin bad++; $display("FAIL b2b_result: got %h want 00024", got); end
    run_op(1'b1, 8'd9, 8'd0, lat, bn, got);
    total++;
    if (lat !== 1 || got !== 17'h109FF) begin
      bad++; $display("FAIL b2b_dbz: got lat=%0d res=%h want lat=1 res=109ff", lat, got);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int lat, bn;
    logic [16:0] got;
    int early_done;
    early_done = 0;
    op = 1'b1; operand_a = 8'd200; operand_b = 8'd7; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) early_done++;
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, div_by_zero, result_lo, result_hi, as_a, as_b, as_subtract, state_dbg} !== 30'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h want 0",
               {busy, done, div_by_zero, result_lo, result_hi, as_a, as_b, as_subtract, state_dbg});
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) early_done++;
    end
    total++;
    if (early_done !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d want 0", early_done); end
    run_op(1'b0, 8'd9, 8'd9, lat, bn, got);
    total++;
    if (got !== 17'h00051 || lat !== 9) begin
      bad++; $display("FAIL midreset_9x9: got lat=%0d res=%h want lat=9 res=00051", lat, got);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bn, exp_lat;
    logic [16:0] got, exp;
    logic o;
    logic [7:0] a, b;
    for (int n = 0; n < 60; n++) begin
      o = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      exp_q.push_back(model_result(o, a, b));
      exp_lat = model_latency(o, a, b);
      run_op(o, a, b, lat, bn, got);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL rand_result op=%0d a=%0d b=%0d: got %h want %h", o, a, b, got, exp);
      end
      total++;
      if (lat !== exp_lat || bn !== exp_lat - 1) begin
        bad++;
        $display("FAIL rand_timing op=%0d a=%0d b=%0d: got lat=%0d busy=%0d want lat=%0d busy=%0d",
                 o, a, b, lat, bn, exp_lat, exp_lat - 1);
      end
      // Gap of zero cycles exercises back-to-back acceptance in DONE.
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // -------------------------------------------------------------------------
  // Sequence and final report
  // -------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    op = 1'b0;
    operand_a = 8'd0;
    operand_b = 8'd0;
    @(negedge clk);
    test_reset();
    test_multiply();
    test_divide();
    test_div_by_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle sequencer that performs 8x8 unsigned multiply (16-bit product) and 8/8 unsigned divide (quotient and remainder).
- It does this by driving one external 8-bit adder_subtractor instance, iteratively.
- Sits between the control unit and the shared adder_subtractor.
- Owns the adder's a/b/subtract inputs and consumes its r/carry outputs.

Parameters:
- ITERATIONS, 8, number of shift/add or shift/subtract steps. Must equal the operand width. Only 8 is supported.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse. Sampled only in IDLE or DONE.
- op  input  1  0 = multiply, 1 = divide. Latched with start.
- operand_a  input  8  multiplicand / dividend
- operand_b  input  8  multiplier / divisor
- busy  output  1  high while an operation is iterating
- done  output  1  one-cycle completion pulse
- result_lo  output  8  product[7:0] / quotient
- result_hi  output  8  product[15:8] / remainder
- div_by_zero  output  1  set on divide with operand_b==0. Valid with done.
- as_a  output  8  to adder_subtractor a
- as_b  output  8  to adder_subtractor b
- as_subtract  output  1  to adder_subtractor subtract
- as_r  input  8  from adder_subtractor r
- as_carry  input  1  from adder_subtractor carry

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high. clk and reset as named above.
- Reset: state=IDLE, count=0. All internal registers (acc, mq, dvsr) are 0. busy, done, div_by_zero, result_lo, result_hi, as_a, as_b and as_subtract are all 0. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, MUL, DIV, DONE.
- IDLE/DONE + start, op=0: latch acc=0, mq=operand_a, dvsr=operand_b, count=0. Go to MUL.
- IDLE/DONE + start, op=1, operand_b!=0: latch acc=0, mq=operand_a, dvsr=operand_b. Go to DIV.
- IDLE/DONE + start, op=1, operand_b==0: go to DONE directly. result_lo=8'hFF, result_hi=operand_a, div_by_zero=1.
- Start while busy (MUL/DIV): ignored, with no effect on the running operation.
- DONE with no start: go to IDLE.
- MUL step (adder drive: as_a=acc, as_b=dvsr, as_subtract=0):
  - sum = mq[0] ? {as_carry, as_r} : {1'b0, acc}.
  - {acc, mq} <= {sum, mq} >> 1, i.e. 17-bit shift right, dropping the old mq[0].
- DIV step, restoring division:
  - {msb, acc_s, mq_s} = {acc, mq} << 1.
  - Adder drive: as_a=acc_s, as_b=dvsr, as_subtract=1.
  - If msb | as_carry: acc<=as_r, mq<={mq_s[7:1], 1}.
  - Otherwise: acc<=acc_s, mq<=mq_s with bit 0 = 0.
  - carry=1 means no borrow. msb=1 guarantees the 9-bit difference fits in 8 bits.
- Count: increments once per step. After the 8th step (count==7), go to DONE.
- Results on entering DONE: result_hi<=acc and result_lo<=mq. div_by_zero=0, except on the divide-by-zero path.
- Timing:
  - busy=1 exactly in MUL/DIV.
  - done=1 exactly in DONE.
  - Latency: start sampled at edge k; done high in the cycle following edge k+8. The divide-by-zero path gives done after edge k.
- Results and div_by_zero hold until the next accepted start or reset. div_by_zero clears on the next accepted start.
- Adder drive in IDLE/DONE: as_a=0, as_b=0, as_subtract=0.
- Back-to-back: a start during DONE is accepted. done is not repeated.

Optional Feature:
- Macro: ALU_SEQ_ZERO_SKIP_EN.
- Defined: if operand_a==0, or if op=0 and operand_b==0, the block goes straight to DONE with result_hi=0, result_lo=0, div_by_zero=0. Latency is 1 cycle and busy never rises. Divide-by-zero still takes priority when op=1 and operand_b==0.
- Undefined: every multiply and every non-zero-divisor divide takes the full 8 iterations, regardless of operand values.

Test Plan:
- Multiply 13 x 11 -> done 9 cycles after start; result_hi=8'h00, result_lo=8'h8F; busy high for exactly 8 cycles.
- Multiply 255 x 255 -> result_hi=8'hFE, result_lo=8'h01, div_by_zero=0.
- Divide 200 / 7 -> result_lo=8'h1C (28), result_hi=8'h04; divide 255 / 1 -> result_lo=8'hFF, result_hi=8'h00.
- Divide 42 / 0 -> done one cycle after start; div_by_zero=1, result_lo=8'hFF, result_hi=8'h2A; busy never rises.
- Multiply 3 x 5 with a second start (6 x 6) pulsed mid-operation -> second start ignored, result 8'h000F. Then start 6 x 6 in the DONE cycle -> accepted, result 8'h0024.
- Reset asserted at iteration 4 of a divide -> next cycle all outputs 0, state IDLE, no done pulse. A following 9 x 9 multiply yields 8'h0051.
